// File: rtl/debug_step_controller.sv
// rtl/debug_step_controller.sv - command sequencer driving debug_enable/single_step of the debug clock-gating unit
module debug_step_controller #(
    parameter int STEP_HI      = 2,
    parameter int STEP_LO      = 2,
    parameter int N_W          = 16,
    parameter bit START_HALTED = 1'b0
) (
    input  logic           sys_clk_ext,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [N_W-1:0] cmd_arg,
    input  logic           abort,
    input  logic [7:0]     clock_counter,
    output logic           debug_enable,
    output logic           single_step,
    output logic           halted,
    output logic           busy,
    output logic           done_pulse,
    output logic           aborted,
    output logic [N_W-1:0] steps_done
);

    localparam int REM_W  = (N_W > 9) ? N_W : 9;
    localparam int PH_MAX = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
    localparam int PH_W   = $clog2(PH_MAX);

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_S_HI, ST_S_LO} state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [REM_W-1:0] remaining;
    logic             run_to;
    logic [7:0]       target;
    logic             abort_req;

    logic             start_zero;
    logic             hit;
    logic [REM_W-1:0] rem_next;
    logic             finish;
    logic [N_W-1:0]   steps_inc;

    // cmd_op[0] distinguishes RUN_TO from STEP once HALT/RUN are excluded
    assign start_zero = cmd_op[0] ? (clock_counter == cmd_arg[7:0]) : (cmd_arg == '0);
    assign hit        = run_to && (clock_counter == target);
    assign rem_next   = remaining - 1'b1;
    assign finish     = (rem_next == '0) || hit || abort_req || abort;
    assign steps_inc  = (steps_done == '1) ? steps_done : steps_done + 1'b1;

    always_ff @(posedge sys_clk_ext or posedge reset) begin
        if (reset) begin
            state        <= START_HALTED ? ST_HALTED : ST_RUN;
            debug_enable <= START_HALTED;
            halted       <= START_HALTED;
            cmd_ready    <= 1'b1;
            single_step  <= 1'b0;
            busy         <= 1'b0;
            done_pulse   <= 1'b0;
            aborted      <= 1'b0;
            steps_done   <= '0;
            phase        <= '0;
            remaining    <= '0;
            run_to       <= 1'b0;
            target       <= '0;
            abort_req    <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                ST_RUN, ST_HALTED: begin
                    if (cmd_valid) begin
                        aborted <= 1'b0;
                        if (cmd_op == OP_HALT) begin
                            state        <= ST_HALTED;
                            debug_enable <= 1'b1;
                            halted       <= 1'b1;
                        end else if (cmd_op == OP_RUN) begin
                            state        <= ST_RUN;
                            debug_enable <= 1'b0;
                            halted       <= 1'b0;
                        end else begin
                            steps_done   <= '0;
                            debug_enable <= 1'b1;
                            target       <= cmd_arg[7:0];
                            run_to       <= cmd_op[0];
                            abort_req    <= 1'b0;
                            phase        <= '0;
                            remaining    <= cmd_op[0] ? REM_W'(256) : REM_W'(cmd_arg);
                            if (start_zero) begin
                                state      <= ST_HALTED;
                                halted     <= 1'b1;
                                done_pulse <= 1'b1;
                            end else begin
                                state       <= ST_S_HI;
                                single_step <= 1'b1;
                                busy        <= 1'b1;
                                cmd_ready   <= 1'b0;
                                halted      <= 1'b0;
                            end
                        end
                    end
                end
                ST_S_HI: begin
                    abort_req <= abort_req | abort;
                    if (phase == PH_W'(STEP_HI - 1)) begin
                        state       <= ST_S_LO;
                        phase       <= '0;
                        single_step <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_S_LO: begin
                    abort_req <= abort_req | abort;
                    if (phase == PH_W'(STEP_LO - 1)) begin
                        phase      <= '0;
                        steps_done <= steps_inc;
                        remaining  <= rem_next;
                        if (finish) begin
                            state      <= ST_HALTED;
                            halted     <= 1'b1;
                            busy       <= 1'b0;
                            cmd_ready  <= 1'b1;
                            done_pulse <= 1'b1;
                            // a target match on the final capped step still counts as success
                            aborted    <= abort_req | abort | (run_to && !hit && (rem_next == '0));
                        end else begin
                            state       <= ST_S_HI;
                            single_step <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_step_controller.sv
// tb/tb_debug_step_controller.sv - randomized self-checking bench with a debug-unit counter model
module tb_debug_step_controller;

    localparam int P = 4;

    logic        sys_clk_ext = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        abort;
    logic [7:0]  clock_counter;
    logic        debug_enable;
    logic        single_step;
    logic        halted;
    logic        busy;
    logic        done_pulse;
    logic        aborted;
    logic [15:0] steps_done;

    debug_step_controller dut (
        .sys_clk_ext   (sys_clk_ext),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_arg       (cmd_arg),
        .abort         (abort),
        .clock_counter (clock_counter),
        .debug_enable  (debug_enable),
        .single_step   (single_step),
        .halted        (halted),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .aborted       (aborted),
        .steps_done    (steps_done)
    );

    always #5 sys_clk_ext = ~sys_clk_ext;

    // debug unit: free-runs when ungated, else one tick per single_step rising edge after 2-flop detect
    logic [7:0] cnt;
    logic       ss_d1, ss_d2;
    logic       freeze;
    logic       load_en;
    logic [7:0] load_val;

    always @(posedge sys_clk_ext) begin
        ss_d1 <= single_step;
        ss_d2 <= ss_d1;
        if (load_en)
            cnt <= load_val;
        else if (!freeze && (!debug_enable || (ss_d1 && !ss_d2)))
            cnt <= cnt + 8'd1;
    end
    assign clock_counter = cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_halted;
    bit exp_aborted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_cnt(input logic [7:0] v);
        @(negedge sys_clk_ext);
        load_en  = 1'b1;
        load_val = v;
        @(negedge sys_clk_ext);
        load_en  = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] arg, input int abort_at);
        logic [7:0] c;
        logic [7:0] exp_cnt;
        int         run_off, natural, exp_steps, cycles, edges, limit;
        bit         imm, cap, exp_ab, prev, leak;

        @(negedge sys_clk_ext);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        check("ready_idle", cmd_ready, 1);
        c       = clock_counter;
        run_off = (exp_halted || freeze) ? 0 : 1;

        if (op == 2'b00 || op == 2'b01) begin
            @(posedge sys_clk_ext);
            #1;
            cmd_valid   = 1'b0;
            exp_halted  = (op == 2'b00);
            exp_aborted = 1'b0;
            check("hr_debug_enable", debug_enable, exp_halted);
            check("hr_halted", halted, exp_halted);
            check("hr_aborted", aborted, 0);
            check("hr_ready", cmd_ready, 1);
            return;
        end

        // expected outcome from the command rules alone
        cap = 1'b0;
        if (op == 2'b10) begin
            imm     = (arg == 16'd0);
            natural = arg;
        end else begin
            imm = (c == arg[7:0]);
            if (freeze) begin
                natural = 256;
                cap     = !imm;
            end else begin
                natural = (int'(arg[7:0]) - int'(c) - run_off) & 255;
                if (natural == 0) natural = 256;
            end
        end
        if (imm) natural = 0;
        exp_steps = (abort_at > 0 && abort_at < natural) ? abort_at : natural;
        exp_ab    = !imm && ((abort_at > 0 && abort_at <= natural) || cap);
        exp_cnt   = freeze ? c : 8'(int'(c) + run_off + exp_steps);

        @(posedge sys_clk_ext);
        #1;
        cmd_valid = 1'b0;
        cycles = 0;
        edges  = 0;
        prev   = 1'b0;
        leak   = 1'b0;
        limit  = exp_steps * P + 8;
        while (!done_pulse && cycles <= limit) begin
            if (single_step && !prev) begin
                edges++;
                if (edges == abort_at) abort = 1'b1;
            end else begin
                abort = 1'b0;
            end
            prev = single_step;
            if (cmd_ready || !busy) leak = 1'b1;
            @(posedge sys_clk_ext);
            #1;
            cycles++;
        end
        abort = 1'b0;
        exp_halted  = 1'b1;
        exp_aborted = exp_ab;
        check("done_seen", done_pulse, 1);
        check("done_latency", cycles, exp_steps * P);
        check("step_edges", edges, exp_steps);
        check("steps_done", steps_done, exp_steps);
        check("aborted", aborted, exp_ab);
        check("halted_end", halted, 1);
        check("debug_enable_end", debug_enable, 1);
        check("ready_end", cmd_ready, 1);
        check("busy_end", busy, 0);
        check("counter_end", clock_counter, exp_cnt);
        check("ready_low_during_burst", leak, 0);
        @(posedge sys_clk_ext);
        #1;
        check("done_one_cycle", done_pulse, 0);
    endtask

    initial begin
        logic [7:0] c1;
        int         edges;
        int         budget;
        logic [1:0] op;
        logic [15:0] arg;
        int         ab;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 16'd0;
        abort     = 1'b0;
        freeze    = 1'b0;
        load_en   = 1'b1;
        load_val  = 8'd0;
        exp_halted  = 1'b0;
        exp_aborted = 1'b0;
        repeat (3) @(posedge sys_clk_ext);
        @(negedge sys_clk_ext);
        load_en = 1'b0;
        reset   = 1'b0;
        @(posedge sys_clk_ext);
        #1;
        check("rst_debug_enable", debug_enable, 0);
        check("rst_single_step", single_step, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_halted", halted, 0);
        check("rst_steps_done", steps_done, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_aborted", aborted, 0);
        c1 = clock_counter;
        repeat (3) @(posedge sys_clk_ext);
        #1;
        check("free_run", clock_counter, 8'(c1 + 8'd3));

        // HALT then STEP 5 from 0x10
        do_cmd(2'b00, 16'd0, 0);
        load_cnt(8'h10);
        do_cmd(2'b10, 16'd5, 0);

        // STEP 0 from RUN, counter must stay frozen afterwards
        do_cmd(2'b01, 16'd0, 0);
        do_cmd(2'b10, 16'd0, 0);
        c1 = clock_counter;
        repeat (3) @(posedge sys_clk_ext);
        #1;
        check("frozen_after_step0", clock_counter, c1);

        // RUN_TO across the wrap, then again at the target
        load_cnt(8'hFE);
        do_cmd(2'b11, 16'h0003, 0);
        check("wrap_counter", clock_counter, 8'h03);
        do_cmd(2'b11, 16'h0003, 0);

        // abort during step 10 of STEP 100
        do_cmd(2'b10, 16'd100, 10);

        // abort while HALTED has no effect
        @(negedge sys_clk_ext);
        abort = 1'b1;
        repeat (3) @(posedge sys_clk_ext);
        #1;
        abort = 1'b0;
        check("abort_idle_halted", halted, 1);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_aborted", aborted, exp_aborted);
        check("abort_idle_steps", steps_done, 10);

        // constant counter: RUN_TO hits the 256-step cap
        freeze = 1'b1;
        do_cmd(2'b11, 16'(clock_counter + 8'd5), 0);
        freeze = 1'b0;

        for (int i = 0; i < 24; i++) begin
            op  = 2'($urandom_range(0, 3));
            ab  = 0;
            if (op == 2'b10) begin
                arg = 16'($urandom_range(0, 12));
            end else if (op == 2'b11) begin
                arg = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255))
                                                  : 16'(clock_counter + 8'($urandom_range(0, 20)));
            end else begin
                arg = 16'($urandom);
            end
            if (op[1] && $urandom_range(0, 3) == 0) ab = $urandom_range(1, 12);
            do_cmd(op, arg, ab);
        end

        // reset asserted in S_LO of step 3 of STEP 8
        do_cmd(2'b00, 16'd0, 0);
        @(negedge sys_clk_ext);
        cmd_op    = 2'b10;
        cmd_arg   = 16'd8;
        cmd_valid = 1'b1;
        @(posedge sys_clk_ext);
        #1;
        cmd_valid = 1'b0;
        edges  = 1;
        budget = 0;
        while (edges < 3 && budget < 40) begin
            @(posedge sys_clk_ext);
            #1;
            budget++;
            if (single_step && budget % P == 0) edges++;
        end
        check("reach_step3", edges, 3);
        repeat (2) @(posedge sys_clk_ext);
        #3;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_debug_enable", debug_enable, 0);
        check("arst_single_step", single_step, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", cmd_ready, 1);
        check("arst_halted", halted, 0);
        check("arst_steps_done", steps_done, 0);
        check("arst_done", done_pulse, 0);
        check("arst_aborted", aborted, 0);
        @(negedge sys_clk_ext);
        reset      = 1'b0;
        exp_halted = 1'b0;
        @(posedge sys_clk_ext);
        #1;
        check("post_rst_halted", halted, 0);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_debug_enable", debug_enable, 0);
        do_cmd(2'b10, 16'd2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
